// File: rtl/mc_controller_ws.sv
// Multicycle MIPS controller with BNE/ADDI/ANDI/ORI/SLTI/J support.
// Define MC_CTRL_MEMWAIT_EN to enable the memready wait/timeout handshake.
module mc_controller_ws #(
   parameter int ALUC_W   = 3,
   parameter int WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic              zero,
   input  logic              memready,
   output logic              pcen,
   output logic              memwrite,
   output logic              irwrite,
   output logic              regwrite,
   output logic              alusrca,
   output logic              iord,
   output logic              memtoreg,
   output logic              regdst,
   output logic              extop,
   output logic [1:0]        alusrcb,
   output logic [1:0]        pcsrc,
   output logic [ALUC_W-1:0] alucontrol,
   output logic              illegal,
   output logic              memtimeout,
   output logic [3:0]        state
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] AC_ADD = 3'b010;
   localparam logic [2:0] AC_SUB = 3'b110;
   localparam logic [2:0] AC_AND = 3'b000;
   localparam logic [2:0] AC_OR  = 3'b001;
   localparam logic [2:0] AC_SLT = 3'b111;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQEX  = 4'd8,
      S_BNEEX  = 4'd9,
      S_IEX    = 4'd10,
      S_IWB    = 4'd11,
      S_JEX    = 4'd12
   } state_e;

   state_e state_q, state_d;
   logic   mr, tmo;

`ifdef MC_CTRL_MEMWAIT_EN
   logic [7:0] wcnt_q, wcnt_d;
   logic       wait_st;

   assign mr      = memready;
   assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                    (state_q == S_MEMWR);
   // Timeout fires on the WAIT_MAX-th consecutive idle cycle.
   assign tmo     = wait_st & ~mr & (wcnt_q == 8'(WAIT_MAX - 1));
   assign wcnt_d  = (wait_st & ~mr & ~tmo) ? wcnt_q + 8'd1 : 8'd0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wcnt_q <= 8'd0;
      else          wcnt_q <= wcnt_d;
   end
`else
   logic unused_memready;
   assign unused_memready = memready;
   assign mr  = 1'b1;
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   logic       pcwrite, branch, bne, irw, mw, rw, ill;
   logic [2:0] aluc;

   always_comb begin
      state_d  = state_q;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      bne      = 1'b0;
      irw      = 1'b0;
      mw       = 1'b0;
      rw       = 1'b0;
      ill      = 1'b0;
      alusrca  = 1'b0;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      extop    = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluc     = 3'b000;
      unique case (state_q)
         S_FETCH: begin
            alusrcb = 2'b01;
            aluc    = AC_ADD;
            irw     = mr;
            pcwrite = mr;
            if (mr) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            aluc    = AC_ADD;
            case (opcode)
               OP_LW, OP_SW:  state_d = S_MEMADR;
               OP_R:          state_d = S_RTEX;
               OP_BEQ:        state_d = S_BEQEX;
               OP_BNE:        state_d = S_BNEEX;
               OP_ADDI, OP_ANDI,
               OP_ORI, OP_SLTI: state_d = S_IEX;
               OP_J:          state_d = S_JEX;
               default: begin
                  ill     = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluc    = AC_ADD;
            state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord = 1'b1;
            if (tmo)     state_d = S_FETCH;
            else if (mr) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            rw       = 1'b1;
            memtoreg = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            iord = 1'b1;
            mw   = 1'b1;
            if (mr || tmo) state_d = S_FETCH;
         end
         S_RTEX: begin
            alusrca = 1'b1;
            state_d = S_RTWB;
            case (funct)
               FN_ADD:  aluc = AC_ADD;
               FN_SUB:  aluc = AC_SUB;
               FN_AND:  aluc = AC_AND;
               FN_OR:   aluc = AC_OR;
               FN_SLT:  aluc = AC_SLT;
               default: begin
                  aluc    = AC_ADD;
                  ill     = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_RTWB: begin
            rw      = 1'b1;
            regdst  = 1'b1;
            state_d = S_FETCH;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluc    = AC_SUB;
            pcsrc   = 2'b01;
            branch  = 1'b1;
            state_d = S_FETCH;
         end
         S_BNEEX: begin
            alusrca = 1'b1;
            aluc    = AC_SUB;
            pcsrc   = 2'b01;
            bne     = 1'b1;
            state_d = S_FETCH;
         end
         S_IEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            extop   = (opcode == OP_ANDI) || (opcode == OP_ORI);
            state_d = S_IWB;
            case (opcode)
               OP_ANDI: aluc = AC_AND;
               OP_ORI:  aluc = AC_OR;
               OP_SLTI: aluc = AC_SLT;
               default: aluc = AC_ADD;
            endcase
         end
         S_IWB: begin
            rw      = 1'b1;
            extop   = (opcode == OP_ANDI) || (opcode == OP_ORI);
            state_d = S_FETCH;
         end
         S_JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Write strobes are gated so nothing writes while reset is held.
   assign pcen       = reset_n & (pcwrite | (branch & zero) | (bne & ~zero));
   assign irwrite    = reset_n & irw;
   assign memwrite   = reset_n & mw;
   assign regwrite   = reset_n & rw;
   assign illegal    = reset_n & ill;
   assign memtimeout = reset_n & tmo;
   assign state      = state_q;

   always_comb begin
      alucontrol      = '0;
      alucontrol[2:0] = aluc;
   end

endmodule

// File: tb/tb_mc_controller_ws.sv
// Randomized bench for mc_controller_ws against an instruction-level model.
// Honours MC_CTRL_MEMWAIT_EN the same way as the design.
module tb_mc_controller_ws;

   localparam int WMAX = 3;
`ifdef MC_CTRL_MEMWAIT_EN
   localparam bit MW = 1'b1;
`else
   localparam bit MW = 1'b0;
`endif

   logic       clk, reset_n, zero, memready;
   logic [5:0] opcode, funct;
   logic       pcen, memwrite, irwrite, regwrite, alusrca, iord;
   logic       memtoreg, regdst, extop, illegal, memtimeout;
   logic [1:0] alusrcb, pcsrc;
   logic [3:0] alucontrol;
   logic [3:0] state;

   int n_checks = 0;
   int n_errors = 0;
   bit pat[$];

   mc_controller_ws #(.ALUC_W(4), .WAIT_MAX(WMAX)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
      .zero(zero), .memready(memready), .pcen(pcen),
      .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
      .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
      .regdst(regdst), .extop(extop), .alusrcb(alusrcb),
      .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal),
      .memtimeout(memtimeout), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic bit fn_ok(input logic [5:0] fn);
      return fn inside {6'b100000, 6'b100010, 6'b100100,
                        6'b100101, 6'b101010};
   endfunction

   function automatic int alu_r(input logic [5:0] fn);
      case (fn)
         6'b100010: return 6;
         6'b100100: return 0;
         6'b100101: return 1;
         6'b101010: return 7;
         default:   return 2;
      endcase
   endfunction

   function automatic int alu_i(input logic [5:0] op);
      case (op)
         6'b001100: return 0;
         6'b001101: return 1;
         6'b001010: return 7;
         default:   return 2;
      endcase
   endfunction

   task automatic check_cycle(input int s, input logic [5:0] op,
                              input logic [5:0] fn, input bit z,
                              input bit mr, input bit tmo);
      bit pc_e, ir_e, mw_e, rw_e, a_e, io_e, mt_e, rd_e, ex_e, il_e;
      int sb_e, ps_e, ac_e;
      bit zx;
      zx   = (op == 6'b001100) || (op == 6'b001101);
      pc_e = (s == 0 && mr) || (s == 8 && z) || (s == 9 && !z) || s == 12;
      ir_e = (s == 0) && mr;
      mw_e = (s == 5);
      rw_e = (s == 4) || (s == 7) || (s == 11);
      a_e  = s inside {2, 6, 8, 9, 10};
      io_e = (s == 3) || (s == 5);
      mt_e = (s == 4);
      rd_e = (s == 7);
      ex_e = (s == 10 || s == 11) && zx;
      sb_e = (s == 0) ? 1 : (s == 1) ? 3 : (s == 2 || s == 10) ? 2 : 0;
      ps_e = (s == 8 || s == 9) ? 1 : (s == 12) ? 2 : 0;
      ac_e = (s <= 2) ? 2 : (s == 6) ? alu_r(fn) :
             (s == 8 || s == 9) ? 6 : (s == 10) ? alu_i(op) : 0;
      il_e = (s == 1 && !(op inside {6'b000000, 6'b000010, 6'b000100,
               6'b000101, 6'b001000, 6'b001010, 6'b001100, 6'b001101,
               6'b100011, 6'b101011})) || (s == 6 && !fn_ok(fn));
      chk("state", 32'(state), 32'(s));
      chk("strobes", 32'({pcen, irwrite, memwrite, regwrite}),
          32'({pc_e, ir_e, mw_e, rw_e}));
      chk("selects", 32'({alusrca, iord, memtoreg, regdst, extop}),
          32'({a_e, io_e, mt_e, rd_e, ex_e}));
      chk("alusrcb", 32'(alusrcb), 32'(sb_e));
      chk("pcsrc", 32'(pcsrc), 32'(ps_e));
      chk("aluctl", 32'(alucontrol), 32'(ac_e));
      chk("flags", 32'({illegal, memtimeout}), 32'({il_e, tmo}));
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_wr"}, 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
      chk({tag, "_flags"}, 32'({illegal, memtimeout}), 32'd0);
      chk({tag, "_srcb"}, 32'(alusrcb), 32'd1);
      chk({tag, "_alu"}, 32'(alucontrol), 32'd2);
   endtask

   task automatic mid_reset();
      memready = 1'b1;
      #1 reset_n = 1'b0;
      #1 reset_checks("rst_mid");
      @(posedge clk);
      #2 reset_checks("rst_hold");
      reset_n = 1'b1;
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int zsel, input int abort_at);
      int  seq[6];
      int  n, w;
      bit  mr_in, mr, tmo, z, mem, done;
      seq = '{0, 1, 0, 0, 0, 0};
      n   = 2;
      case (op)
         6'b100011: begin seq = '{0, 1, 2, 3, 4, 0}; n = 5; end
         6'b101011: begin seq = '{0, 1, 2, 5, 0, 0}; n = 4; end
         6'b000000: begin
            seq = '{0, 1, 6, 7, 0, 0};
            n   = fn_ok(fn) ? 4 : 3;
         end
         6'b000100: begin seq = '{0, 1, 8, 0, 0, 0}; n = 3; end
         6'b000101: begin seq = '{0, 1, 9, 0, 0, 0}; n = 3; end
         6'b000010: begin seq = '{0, 1, 12, 0, 0, 0}; n = 3; end
         6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
            seq = '{0, 1, 10, 11, 0, 0}; n = 4;
         end
         default: n = 2;
      endcase
      done = 1'b0;
      for (int i = 0; i < n && !done; i++) begin
         w = 0;
         for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            opcode = op;
            funct  = fn;
            z      = (zsel == 2) ? bit'($urandom_range(1)) : (zsel == 1);
            zero   = z;
            if (pat.size() > 0) mr_in = pat.pop_front();
            else                mr_in = ($urandom_range(9) < 7);
            memready = mr_in;
            mr  = MW ? mr_in : 1'b1;
            mem = (seq[i] == 0) || (seq[i] == 3) || (seq[i] == 5);
            tmo = MW && mem && !mr && (w + 1 == WMAX);
            #1 check_cycle(seq[i], op, fn, z, mr, tmo);
            if (seq[i] == abort_at) begin
               mid_reset();
               done = 1'b1;
               break;
            end
            if (!mem || mr) break;
            if (tmo) begin
               done = 1'b1;
               break;
            end
            w++;
         end
      end
      pat.delete();
   endtask

   logic [5:0] ops [13];
   logic [5:0] fns [5];

   initial begin
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
              6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010,
              6'b111111, 6'b000001, 6'b100000};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      reset_n  = 1'b0;
      opcode   = 6'($urandom);
      funct    = 6'($urandom);
      zero     = 1'b0;
      memready = 1'b1;
      #3 reset_checks("rst_a");
      #5 reset_checks("rst_b");
      #1 reset_n = 1'b1;

      run_instr(6'b100011, 6'b0, 2, -1);
      run_instr(6'b000101, 6'b0, 0, -1);
      run_instr(6'b000100, 6'b0, 0, -1);
      run_instr(6'b000100, 6'b0, 1, -1);
      run_instr(6'b001101, 6'b0, 2, -1);
      run_instr(6'b111111, 6'b0, 2, -1);
      run_instr(6'b000000, 6'b000000, 2, -1);
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      run_instr(6'b101011, 6'b0, 2, -1);
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      run_instr(6'b101011, 6'b0, 2, -1);
      pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      run_instr(6'b100011, 6'b0, 2, 4);

      for (int k = 0; k < 300; k++) begin
         logic [5:0] op, fn;
         op = ops[$urandom_range(12)];
         fn = ($urandom_range(3) == 0) ? 6'($urandom) : fns[$urandom_range(4)];
         run_instr(op, fn, 2, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mc_controller_ws.md
# mc_controller_ws

Parametrised multicycle MIPS controller, successor to the fixed-width `controller`. It decodes `opcode`/`funct` into datapath strobes for the Lafayette multicycle datapath. It extends the instruction set with BNE, ADDI, ANDI, ORI, SLTI and J, and adds memory wait-state handling with a timeout. It sits between the instruction register and the multicycle datapath, replacing `controller` one-for-one.

## Interface
- `ALUC_W`, 3: `alucontrol` width (≥3); bits above [2] are driven 0.
- `WAIT_MAX`, 15: maximum consecutive wait cycles per memory access before timeout (1..255).
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: instr[31:26] (`mips_decls_p::opcode_t`).
- `funct` in 6: instr[5:0] (`mips_decls_p::funct_t`).
- `zero` in 1: ALU zero flag.
- `memready` in 1: memory completes current access this cycle.
- `pcen`, `memwrite`, `irwrite`, `regwrite` out 1: write enables.
- `alusrca`, `iord`, `memtoreg`, `regdst` out 1: mux selects.
- `extop` out 1: 1 = zero-extend immediate (ANDI/ORI), 0 = sign-extend.
- `alusrcb`, `pcsrc` out 2: mux selects.
- `alucontrol` out ALUC_W: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.
- `memtimeout` out 1: one-cycle pulse when a wait exceeds WAIT_MAX.
- `state` out 4: current state encoding, for debug.

## Operation
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), RTEX(6), RTWB(7), BEQEX(8), BNEEX(9), IEX(10), IWB(11), JEX(12).
- Default output value is 0 unless listed below.
- FETCH: iord=0, alusrcb=01, alucontrol=add, irwrite=pcwrite=memready. Transition to DECODE on memready, otherwise stay in FETCH.
- DECODE: alusrcb=11, alucontrol=add. Next state by opcode:
  - LW/SW → MEMADR
  - R(000000) → RTEX
  - BEQ(000100) → BEQEX
  - BNE(000101) → BNEEX
  - ADDI(001000)/ANDI(001100)/ORI(001101)/SLTI(001010) → IEX
  - J(000010) → JEX
  - any other opcode: pulse `illegal` and go to FETCH.
- MEMADR: alusrca=1, alusrcb=10, add. LW(100011) → MEMRD; SW(101011) → MEMWR.
- MEMRD: iord=1. On memready → MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next state FETCH.
- MEMWR: iord=1, memwrite=1, held until memready. Next state FETCH.
- RTEX: alusrca=1, alusrcb=00, alucontrol from funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010. Next state RTWB.
  - Any other funct: alucontrol=add, pulse `illegal`, go to FETCH with no writeback.
- RTWB: regwrite=1, regdst=1, memtoreg=0. Next state FETCH.
- BEQEX/BNEEX: alusrca=1, alucontrol=sub, pcsrc=01. branch=1 in BEQEX, bne=1 in BNEEX. Next state FETCH.
- IEX: alusrca=1, alusrcb=10, alucontrol per opcode (add/and/or/slt). extop=1 for ANDI/ORI. Next state IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. extop is held. Next state FETCH.
- JEX: pcsrc=10, pcwrite=1. Next state FETCH.
- pcen = pcwrite | (branch & zero) | (bne & ~zero). This is combinational from state and `zero`.

## Timing
- All outputs except `pcen` are Moore outputs decoded from registered state. In FETCH/MEMWR they also depend on `memready`.
- Instruction cycle counts with memready=1 throughout:
  - LW: 5
  - SW, R-type, ADDI/ANDI/ORI/SLTI: 4
  - BEQ, BNE, J: 3
  - illegal instruction: 2
- Wait counter: cleared on entry to FETCH/MEMRD/MEMWR and incremented each cycle memready=0 there.
  - When the count reaches WAIT_MAX with memready still 0, pulse `memtimeout` and go to FETCH. The counter clears on that transition.
  - An aborted fetch writes neither PC nor IR. An aborted SW has memwrite deasserted the next cycle.
- memready=1 on the same cycle the count reaches WAIT_MAX: completion wins, no timeout.
- While reset_n=0:
  - state=FETCH and the wait counter is 0.
  - pcen, irwrite, memwrite, regwrite, illegal and memtimeout are forced to 0.
  - The other outputs take FETCH values: alusrcb=01, alucontrol=010.
- After reset_n rises, the first FETCH cycle is at the next rising edge.
- Reset asserted mid-instruction aborts immediately, with no partial writes after assertion.

## Configuration
- `MC_CTRL_MEMWAIT_EN` defined: `memready` handshake, wait counter and `memtimeout` are active as described above.
- `MC_CTRL_MEMWAIT_EN` undefined:
  - `memready` is ignored and treated as 1.
  - The counter is not built, and `memtimeout` is tied to 0.
  - FETCH/MEMRD/MEMWR each last exactly one cycle.

## Test plan
- Reset: hold reset_n=0 for 9 ns with random opcode → state=0, pcen=irwrite=memwrite=regwrite=0, alusrcb=01, alucontrol=010.
- LW, memready=1: states 0,1,2,3,4,0 → regwrite=1 with memtoreg=1 in cycle 5 only.
- BNE with zero=0, then BEQ with zero=0: pcen=1 in BNEEX; pcen=0 in BEQEX. BEQ with zero=1: pcen=1.
- ORI (001101): IEX asserts extop=1 and alucontrol=001. IWB asserts regwrite=1 and regdst=0.
- Illegal opcode 111111, then R-type with funct 000000: `illegal` pulses in DECODE and in RTEX respectively, and regwrite never asserts.
- MEMWAIT_EN, WAIT_MAX=3, SW with memready low for 3 cycles: memtimeout pulses once, memwrite drops, state returns to 0. Repeat with memready high on the 3rd wait → no timeout, next state FETCH.
